// File: rtl/session_scheduler_if.sv
// Handshake bundle between requesters, the shared resource port and the
// session scheduler. The master drives requests and beats; the slave (the
// scheduler) drives the grant and session status.
interface session_scheduler_if;
    logic [3:0] req;
    logic [3:0] last;
    logic       beat_valid;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       session_done;
    logic       timeout_err;
    logic       busy;

    modport master (
        output req, last, beat_valid,
        input  grant, grant_id, session_done, timeout_err, busy
    );

    modport slave (
        input  req, last, beat_valid,
        output grant, grant_id, session_done, timeout_err, busy
    );
endinterface

// File: rtl/session_scheduler.sv
// Session scheduler for a 4-requester shared port. A round-robin winner holds
// the grant for a whole session. The session ends on a last beat, the burst
// quota, owner withdrawal or an idle timeout. Priority then rotates past the
// finished owner, and a mandatory one-cycle gap separates consecutive sessions.
module session_scheduler #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst_a,
    session_scheduler_if.slave  bus
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    id_q, id_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    grant_q, grant_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;
    logic          busy_q, busy_d;

    logic [1:0]    winner;
    logic          any_req;
    logic          end_now;

    // Round-robin pick: the first requester found scanning ptr, ptr+1, ... mod 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner  = ptr_q;
        any_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!any_req && bus.req[ptr_q + 2'(i)]) begin
                winner  = ptr_q + 2'(i);
                any_req = 1'b1;
            end
        end
    end

    // Next-state logic: arbitration in IDLE/DONE and session tracking in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        terr_d  = 1'b0;
        end_now = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (any_req) begin
                    grant_d = 4'b0001 << winner;
                    id_d    = winner;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    idle_d  = '0;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // End conditions in priority order: last beat, quota, withdraw, timeout.
                if (bus.beat_valid) begin
                    if (bus.last[id_q] || beat_q == BW'(MAX_BURST - 1)) begin
                        end_now = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        idle_d = '0;
                    end
                end else if (!bus.req[id_q]) begin
                    end_now = 1'b1;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    end_now = 1'b1;
                    terr_d  = 1'b1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end

                if (end_now) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = id_q + 2'd1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything at once.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = id_q;
    assign bus.session_done = done_q;
    assign bus.timeout_err  = terr_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_session_scheduler.sv
// Self-checking bench for session_scheduler. It runs directed sessions from the
// test plan and then random traffic. Every cycle is checked against a session
// model that tracks owner, beat count and idle count as plain integers.
module tb_session_scheduler;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 64;

    logic clk = 1'b0;
    logic rst_a;
    session_scheduler_if bus ();

    session_scheduler #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Session model: owner -1 means no session in progress.
    int         m_owner;
    int         m_ptr;
    int         m_beats;
    int         m_idle;
    logic [1:0] m_id;
    logic       m_done;
    logic       m_terr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_idle  = 0;
        m_id    = 2'd0;
        m_done  = 1'b0;
        m_terr  = 1'b0;
    endtask

    task automatic model_end(input bit by_timeout);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_done  = 1'b1;
        m_terr  = by_timeout;
    endtask

    task automatic model_cycle(input logic [3:0] r, input logic [3:0] l, input logic b);
        m_done = 1'b0;
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            if (b && l[m_owner])                    model_end(1'b0);
            else if (b && m_beats + 1 == MAX_BURST) model_end(1'b0);
            else if (!b && !r[m_owner])             model_end(1'b0);
            else if (!b && m_idle + 1 == TIMEOUT)   model_end(1'b1);
            else if (b) begin
                m_beats++;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 0; k < 4; k++)
                if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_id    = m_owner[1:0];
            m_beats = 0;
            m_idle  = 0;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".grant"}, 32'(bus.grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(m_id));
        check({tag, ".done"}, 32'(bus.session_done), 32'(m_done));
        check({tag, ".terr"}, 32'(bus.timeout_err), 32'(m_terr));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
    endtask

    // One clock: drive inputs, let the DUT sample them, update the model, compare.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l, input logic b);
        bus.req        = r;
        bus.last       = l;
        bus.beat_valid = b;
        @(posedge clk);
        model_cycle(r, l, b);
        #1;
        compare(tag);
    endtask

    initial begin
        logic [3:0] rr;
        logic [3:0] ll;

        rst_a          = 1'b1;
        bus.req        = 4'b0000;
        bus.last       = 4'b0000;
        bus.beat_valid = 1'b0;
        model_reset();
        #2;
        compare("reset");
        @(posedge clk);
        #3;
        rst_a = 1'b0;

        // Full rotation, three beats per session with last on the third.
        step("t1_first", 4'b1111, 4'b0000, 1'b0);
        check("t1_first_owner", 32'(bus.grant), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step("t1_beat", 4'b1111, 4'b0000, 1'b1);
            step("t1_beat", 4'b1111, 4'b0000, 1'b1);
            step("t1_last", 4'b1111, 4'b1111, 1'b1);
            check("t1_done", 32'(bus.session_done), 32'd1);
            check("t1_gap", 32'(bus.grant), 32'd0);
            step("t1_regrant", 4'b1111, 4'b0000, 1'b0);
            check("t1_rotate", 32'(bus.grant), 32'(1 << ((k + 1) % 4)));
        end
        step("t1_drop", 4'b0000, 4'b0000, 1'b0);
        step("t1_idle", 4'b0000, 4'b0000, 1'b0);

        // Burst quota: 20 beats from requester 2 only.
        step("t2_grant", 4'b0100, 4'b0000, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            step("t2_beat", 4'b0100, 4'b0000, 1'b1);
            if (j == 16) check("t2_quota_done", 32'(bus.session_done), 32'd1);
            if (j == 17) check("t2_regrant", 32'(bus.grant), 32'h4);
        end
        step("t2_drop", 4'b0000, 4'b0000, 1'b0);
        step("t2_idle", 4'b0000, 4'b0000, 1'b0);

        // Idle timeout with the request held.
        step("t3_grant", 4'b0010, 4'b0000, 1'b0);
        check("t3_owner", 32'(bus.grant), 32'h2);
        for (int j = 1; j <= 64; j++) begin
            step("t3_wait", 4'b0010, 4'b0000, 1'b0);
            if (j == 63) check("t3_not_yet", 32'(bus.session_done), 32'd0);
        end
        check("t3_timeout_done", 32'(bus.session_done), 32'd1);
        check("t3_timeout_err", 32'(bus.timeout_err), 32'd1);
        step("t3_drop", 4'b0000, 4'b0000, 1'b0);

        // Owner 3 withdraws after five beats; pending requester 0 follows.
        step("t4_grant", 4'b1001, 4'b0000, 1'b0);
        check("t4_owner", 32'(bus.grant), 32'h8);
        for (int j = 0; j < 5; j++) step("t4_beat", 4'b1001, 4'b0000, 1'b1);
        step("t4_withdraw", 4'b0001, 4'b0000, 1'b0);
        check("t4_done", 32'(bus.session_done), 32'd1);
        check("t4_no_terr", 32'(bus.timeout_err), 32'd0);
        step("t4_next", 4'b0001, 4'b0000, 1'b0);
        check("t4_next_owner", 32'(bus.grant), 32'h1);
        step("t4_beat", 4'b0001, 4'b0000, 1'b1);
        step("t4_beat", 4'b0001, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a burst.
        #3;
        rst_a = 1'b1;
        #1;
        check("t5_async_grant", 32'(bus.grant), 32'd0);
        check("t5_async_busy", 32'(bus.busy), 32'd0);
        model_reset();
        compare("t5_reset");
        @(posedge clk);
        #4;
        bus.req = 4'b1010;
        rst_a   = 1'b0;
        step("t5_after", 4'b1010, 4'b0000, 1'b0);
        check("t5_owner", 32'(bus.grant), 32'h2);

        // Last on the 16th beat gives exactly one end.
        for (int j = 1; j <= 16; j++)
            step("t6_beat", 4'b1010, (j == 16) ? 4'b0010 : 4'b0000, 1'b1);
        check("t6_done", 32'(bus.session_done), 32'd1);
        step("t6_regrant", 4'b0010, 4'b0000, 1'b0);
        check("t6_single_done", 32'(bus.session_done), 32'd0);
        check("t6_owner", 32'(bus.grant), 32'h2);
        // Withdrawal beats timeout when both occur in the same cycle.
        for (int j = 1; j <= 63; j++) step("t6_wait", 4'b0010, 4'b0000, 1'b0);
        step("t6_withdraw", 4'b0000, 4'b0000, 1'b0);
        check("t6_withdraw_done", 32'(bus.session_done), 32'd1);
        check("t6_withdraw_terr", 32'(bus.timeout_err), 32'd0);
        step("t6_idle", 4'b0000, 4'b0000, 1'b0);

        // Random traffic: slowly changing requests, random beats, sparse last bits.
        rr = 4'b1111;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            ll = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            step("rand", rr, ll, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
